pipeline_alu_param: RTL and testbench

PIPELINE_ALU_PARAM -- requirements
Module: pipeline_alu_param

---
 rtl/pipeline_alu_param.sv | 124 ++++++++++++
 tb/tb_pipeline_alu_param.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_alu_param.sv
// rtl/pipeline_alu_param.sv - three-stage valid/ready arithmetic pipeline
//
// Purpose:
//    Computes F = op(((a+b) + (c-d)), d) over three register stages, where op
//    is selected by mode: 00 multiply, 01 add, 10 subtract, 11 pass-through.
//    All arithmetic is unsigned, modulo 2^M. The whole pipe advances as a
//    unit; a stalled output freezes every stage.
//
// Ports:
//    clk1       in   1   clock, rising edge
//    rst_n      in   1   synchronous active-low reset
//    a,b,c,d    in   N   unsigned operands
//    mode       in   2   stage-3 operation select, travels with its operands
//    in_valid   in   1   operand set presented
//    in_ready   out  1   operand set accepted when in_valid & in_ready
//    F          out  M   result
//    out_valid  out  1   F holds a valid result
//    out_ready  in   1   downstream consumes F this cycle
//    inflight   out  2   number of valid stages (0..3)

module pipeline_alu_param #(
   parameter int N = 4,
   parameter int M = 3 * N
) (
   input  logic         clk1,
   input  logic         rst_n,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [N-1:0] c,
   input  logic [N-1:0] d,
   input  logic [1:0]   mode,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [M-1:0] F,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [1:0]   inflight
);

   localparam logic [1:0] MODE_MUL  = 2'b00;
   localparam logic [1:0] MODE_ADD  = 2'b01;
   localparam logic [1:0] MODE_SUB  = 2'b10;
   localparam logic [1:0] MODE_PASS = 2'b11;

   // Stage 1: partial sums plus the operand and mode needed later
   logic [M-1:0] s1_x1;
   logic [M-1:0] s1_x2;
   logic [N-1:0] s1_d;
   logic [1:0]   s1_mode;
   logic         s1_v;

   // Stage 2: combined sum plus d/mode for the final operation
   logic [M-1:0] s2_x3;
   logic [N-1:0] s2_d;
   logic [1:0]   s2_mode;
   logic         s2_v;

   // Stage 3: result register driving F
   logic [M-1:0] s3_f;
   logic         s3_v;

   logic         advance;
   logic [M-1:0] x1_next;
   logic [M-1:0] x2_next;
   logic [M-1:0] x3_next;
   logic [M-1:0] d_ext;
   logic [M-1:0] f_next;

   // The only stall source is a held, unconsumed result in stage 3; the
   // whole pipe moves together, so bubbles in S1/S2 are not compressed.
   assign advance  = !s3_v || out_ready;
   assign in_ready = advance;

   assign F         = s3_f;
   assign out_valid = s3_v;
   assign inflight  = {1'b0, s1_v} + {1'b0, s2_v} + {1'b0, s3_v};

   always_comb begin
      x1_next = M'(a) + M'(b);
      // c-d is done at full M width so a negative difference wraps to 2^M-k
      x2_next = M'(c) - M'(d);
      x3_next = s1_x1 + s1_x2;
      d_ext   = M'(s2_d);
      f_next  = s2_x3;
      case (s2_mode)
         // Product is truncated to the low M bits by the M-bit context
         MODE_MUL:  f_next = s2_x3 * d_ext;
         MODE_ADD:  f_next = s2_x3 + d_ext;
         MODE_SUB:  f_next = s2_x3 - d_ext;
         MODE_PASS: f_next = s2_x3;
         default:   f_next = s2_x3;
      endcase
   end

   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         s1_x1   <= '0;
         s1_x2   <= '0;
         s1_d    <= '0;
         s1_mode <= '0;
         s1_v    <= 1'b0;
         s2_x3   <= '0;
         s2_d    <= '0;
         s2_mode <= '0;
         s2_v    <= 1'b0;
         s3_f    <= '0;
         s3_v    <= 1'b0;
      end else if (advance) begin
         // S1 data loads unconditionally; only the valid bit marks it as real
         s1_x1   <= x1_next;
         s1_x2   <= x2_next;
         s1_d    <= d;
         s1_mode <= mode;
         s1_v    <= in_valid;
         s2_x3   <= x3_next;
         s2_d    <= s1_d;
         s2_mode <= s1_mode;
         s2_v    <= s1_v;
         s3_f    <= f_next;
         s3_v    <= s2_v;
      end
   end

endmodule

// File: tb/tb_pipeline_alu_param.sv
// tb/tb_pipeline_alu_param.sv - scoreboard bench for pipeline_alu_param

module tb_pipeline_alu_param;

   localparam int N   = 4;
   localparam int M   = 12;
   localparam int MOD = 1 << M;

   logic         clk1;
   logic         rst_n;
   logic [N-1:0] a, b, c, d;
   logic [1:0]   mode;
   logic         in_valid;
   logic         in_ready;
   logic [M-1:0] F;
   logic         out_valid;
   logic         out_ready;
   logic [1:0]   inflight;

   int tests_run = 0;
   int fails     = 0;
   int popped    = 0;
   logic [M-1:0] sb_q[$];

   pipeline_alu_param #(.N(N), .M(M)) dut (
      .clk1      (clk1),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .c         (c),
      .d         (d),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .F         (F),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .inflight  (inflight)
   );

   initial clk1 = 1'b0;
   always #5 clk1 = ~clk1;

   function automatic logic [M-1:0] model(input int ia, input int ib, input int ic,
                                          input int id, input logic [1:0] im);
      int x1;
      int x2;
      int x3;
      int r;
      x1 = (ia + ib) % MOD;
      x2 = (ic - id + MOD) % MOD;
      x3 = (x1 + x2) % MOD;
      case (im)
         2'b00:   r = (x3 * id) % MOD;
         2'b01:   r = (x3 + id) % MOD;
         2'b10:   r = (x3 - id + MOD) % MOD;
         default: r = x3;
      endcase
      return r[M-1:0];
   endfunction

   // Scoreboard: push on accepted input, pop on consumed output.
   // Sampled at negedge; inputs only change just after posedge.
   always @(negedge clk1) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            tests_run++;
            if (sb_q.size() == 0) begin
               fails++;
               $display("FAIL scoreboard_unexpected got F=%0d expected no output", F);
            end else begin
               logic [M-1:0] exp_f;
               exp_f = sb_q.pop_front();
               if (F !== exp_f) begin
                  fails++;
                  $display("FAIL scoreboard_F got %0d expected %0d", F, exp_f);
               end
               popped++;
            end
         end
         if (in_valid && in_ready)
            sb_q.push_back(model(int'(a), int'(b), int'(c), int'(d), mode));
      end
   end

   task automatic drive(input logic [N-1:0] ta, input logic [N-1:0] tb_,
                        input logic [N-1:0] tc, input logic [N-1:0] td,
                        input logic [1:0] tm, input logic tv);
      a = ta; b = tb_; c = tc; d = td; mode = tm; in_valid = tv;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; out_ready = 1'b1;
      drive(0, 0, 0, 0, 2'b00, 1'b0);
      repeat (2) @(posedge clk1);
      @(negedge clk1);
      tests_run++;
      if (out_valid !== 1'b0 || F !== '0 || inflight !== 2'd0) begin
         fails++;
         $display("FAIL reset_state got ov=%0b F=%0d inf=%0d expected 0/0/0", out_valid, F, inflight);
      end
      tests_run++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_in_ready got %0b expected 1", in_ready);
      end
      @(posedge clk1); #1;
      rst_n = 1'b1;
      @(negedge clk1);
      tests_run++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL post_reset_in_ready got %0b expected 1", in_ready);
      end
      @(posedge clk1); #1;
   endtask

   task automatic test_basic;
      out_ready = 1'b1;
      drive(3, 4, 9, 2, 2'b00, 1'b1);
      for (int j = 1; j <= 3; j++) begin
         @(posedge clk1); #1;
         in_valid = 1'b0;
         @(negedge clk1);
         tests_run++;
         if (out_valid !== (j == 3)) begin
            fails++;
            $display("FAIL basic_latency step %0d got ov=%0b expected %0b", j, out_valid, (j == 3));
         end
      end
      tests_run++;
      if (F !== 12'd28) begin
         fails++;
         $display("FAIL basic_F got %0d expected 28", F);
      end
      @(posedge clk1); #1;
      repeat (2) @(posedge clk1);
      #1;
   endtask

   task automatic run_four(input string name, input logic [N-1:0] ta[4], input logic [N-1:0] tb_[4],
                           input logic [N-1:0] tc[4], input logic [N-1:0] td[4],
                           input logic [1:0] tm[4], input logic [M-1:0] exp_f[4], input int cnt);
      out_ready = 1'b1;
      drive(ta[0], tb_[0], tc[0], td[0], tm[0], 1'b1);
      for (int i = 1; i < 4; i++) begin
         @(posedge clk1); #1;
         if (i < cnt) drive(ta[i], tb_[i], tc[i], td[i], tm[i], 1'b1);
         else in_valid = 1'b0;
      end
      for (int i = 0; i < cnt; i++) begin
         @(negedge clk1);
         tests_run++;
         if (out_valid !== 1'b1 || F !== exp_f[i]) begin
            fails++;
            $display("FAIL %s result %0d got ov=%0b F=%0d expected ov=1 F=%0d", name, i, out_valid, F, exp_f[i]);
         end
         @(posedge clk1); #1;
         in_valid = 1'b0;
      end
      repeat (4) @(posedge clk1);
      #1;
   endtask

   task automatic test_modes;
      logic [N-1:0] ta[4], tb_[4], tc[4], td[4];
      logic [1:0]   tm[4];
      logic [M-1:0] ef[4];
      for (int i = 0; i < 4; i++) begin
         ta[i] = 3; tb_[i] = 4; tc[i] = 9; td[i] = 2; tm[i] = 2'(i);
      end
      ef[0] = 28; ef[1] = 16; ef[2] = 12; ef[3] = 14;
      run_four("modes", ta, tb_, tc, td, tm, ef, 4);
   endtask

   task automatic test_wrap;
      logic [N-1:0] ta[4], tb_[4], tc[4], td[4];
      logic [1:0]   tm[4];
      logic [M-1:0] ef[4];
      ta[0] = 15; tb_[0] = 15; tc[0] = 0; td[0] = 15; tm[0] = 2'b00; ef[0] = 225;
      ta[1] = 0;  tb_[1] = 0;  tc[1] = 0; td[1] = 1;  tm[1] = 2'b10; ef[1] = 12'hFFE;
      for (int i = 2; i < 4; i++) begin
         ta[i] = 0; tb_[i] = 0; tc[i] = 0; td[i] = 0; tm[i] = 2'b11; ef[i] = 0;
      end
      run_four("wrap", ta, tb_, tc, td, tm, ef, 2);
   endtask

   task automatic test_stall;
      logic [N-1:0] sa[5], sb[5], sc[5], sd[5];
      logic [1:0]   sm[5];
      logic [M-1:0] first_f;
      int idx;
      int start_pop;
      for (int i = 0; i < 5; i++) begin
         sa[i] = 4'($urandom); sb[i] = 4'($urandom); sc[i] = 4'($urandom);
         sd[i] = 4'($urandom); sm[i] = 2'($urandom);
      end
      first_f   = model(int'(sa[0]), int'(sb[0]), int'(sc[0]), int'(sd[0]), sm[0]);
      idx       = 0;
      start_pop = popped;
      for (int cyc = 0; cyc < 40; cyc++) begin
         out_ready = !(cyc >= 3 && cyc <= 6);
         if (idx < 5) drive(sa[idx], sb[idx], sc[idx], sd[idx], sm[idx], 1'b1);
         else in_valid = 1'b0;
         @(negedge clk1);
         if (cyc >= 3 && cyc <= 6) begin
            tests_run++;
            if (out_valid !== 1'b1 || F !== first_f || in_ready !== 1'b0 || inflight !== 2'd3) begin
               fails++;
               $display("FAIL stall_hold cyc %0d got ov=%0b F=%0d rdy=%0b inf=%0d expected 1/%0d/0/3",
                        cyc, out_valid, F, in_ready, inflight, first_f);
            end
         end
         if (in_valid && in_ready) idx++;
         @(posedge clk1); #1;
         if (idx == 5 && popped - start_pop == 5) break;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tests_run++;
      if (popped - start_pop != 5 || sb_q.size() != 0) begin
         fails++;
         $display("FAIL stall_count got %0d results, %0d pending expected 5 results, 0 pending",
                  popped - start_pop, sb_q.size());
      end
      repeat (2) @(posedge clk1);
      #1;
   endtask

   task automatic test_bubbles;
      int inf_exp[6];
      int ov_exp[3];
      inf_exp = '{1, 1, 2, 1, 1, 0};
      ov_exp  = '{1, 0, 1};
      out_ready = 1'b1;
      for (int cyc = 0; cyc <= 6; cyc++) begin
         drive(4'(cyc + 1), 4'(cyc), 4'(7), 4'(3), 2'b01, (cyc == 0 || cyc == 2));
         @(negedge clk1);
         if (cyc >= 1) begin
            tests_run++;
            if (int'(inflight) != inf_exp[cyc-1]) begin
               fails++;
               $display("FAIL bubble_inflight cyc %0d got %0d expected %0d", cyc, inflight, inf_exp[cyc-1]);
            end
         end
         if (cyc >= 3 && cyc <= 5) begin
            tests_run++;
            if (int'(out_valid) != ov_exp[cyc-3]) begin
               fails++;
               $display("FAIL bubble_out_valid cyc %0d got %0b expected %0d", cyc, out_valid, ov_exp[cyc-3]);
            end
         end
         @(posedge clk1); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_mid;
      int start_pop;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 3; cyc++) begin
         drive(4'(cyc + 5), 4'(2), 4'(cyc), 4'(1), 2'(cyc), 1'b1);
         @(posedge clk1); #1;
      end
      // Reset edge also sees a valid input that must not be stored
      drive(4'(9), 4'(9), 4'(9), 4'(9), 2'b01, 1'b1);
      rst_n = 1'b0;
      @(negedge clk1);
      tests_run++;
      if (inflight !== 2'd3) begin
         fails++;
         $display("FAIL reset_mid_pre_inflight got %0d expected 3", inflight);
      end
      @(posedge clk1); #1;
      rst_n = 1'b1;
      sb_q.delete();
      start_pop = popped;
      in_valid = 1'b0;
      @(negedge clk1);
      tests_run++;
      if (out_valid !== 1'b0 || F !== '0 || inflight !== 2'd0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_mid_clear got ov=%0b F=%0d inf=%0d rdy=%0b expected 0/0/0/1",
                  out_valid, F, inflight, in_ready);
      end
      @(posedge clk1); #1;
      drive(4'(6), 4'(1), 4'(8), 4'(5), 2'b00, 1'b1);
      @(posedge clk1); #1;
      in_valid = 1'b0;
      repeat (8) @(posedge clk1);
      #1;
      tests_run++;
      if (popped - start_pop != 1 || sb_q.size() != 0) begin
         fails++;
         $display("FAIL reset_mid_after got %0d results, %0d pending expected 1 result, 0 pending",
                  popped - start_pop, sb_q.size());
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_modes;
      test_wrap;
      test_stall;
      test_bubbles;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation did not complete expected finish before 200000");
      $fatal(1);
   end

endmodule
